// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-requester round-robin TX FIFO scheduler feeding the UART core
// Optional feature macro: UART_TX_SCHED_CRLF_EN (send 8'h0D ahead of every 8'h0A)

module uart_tx_sched #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req0_valid,
  input  logic [7:0]    req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [7:0]    req1_data,
  output logic          req1_ready,
  output logic [7:0]    tx_data,
  output logic          tx_data_valid,
  input  logic          tx_data_ack,
  output logic [AW:0]   fifo_count,
  output logic          fifo_full,
  output logic          fifo_empty,
  output logic          busy
);

  localparam logic [AW:0]   DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          last_grant;
  logic          grant0;
  logic          grant1;
  logic          push;
  logic          pop;
  logic [7:0]    push_data;
  logic [7:0]    head;

`ifdef UART_TX_SCHED_CRLF_EN
  logic cr_done;
  logic cr_needed;
  // An LF at the head that has not yet had its CR sent must stay queued
  assign cr_needed = (head == 8'h0A) && !cr_done;
  assign pop       = (state == IDLE) && !fifo_empty && !cr_needed;
`else
  assign pop       = (state == IDLE) && !fifo_empty;
`endif

  assign fifo_full  = (fifo_count == DEPTH_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign busy       = (state != IDLE) || !fifo_empty;
  assign head       = mem[rd_ptr];

  // Round-robin arbiter: on contention the requester that did not win last time is served
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!fifo_full) begin
      if (req0_valid && req1_valid) begin
        grant0 = (last_grant == 1'b1);
        grant1 = (last_grant == 1'b0);
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign push       = grant0 || grant1;
  assign push_data  = grant0 ? req0_data : req1_data;

  // FIFO storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and arbitration history
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_grant <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_ONE;
        last_grant <= grant1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Transmit FSM: load a byte in IDLE, hold it in SEND until the core acknowledges
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      tx_data       <= 8'h00;
      tx_data_valid <= 1'b0;
`ifdef UART_TX_SCHED_CRLF_EN
      cr_done       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
`ifdef UART_TX_SCHED_CRLF_EN
            if (cr_needed) begin
              tx_data <= 8'h0D;
              cr_done <= 1'b1;
            end else begin
              tx_data <= head;
              cr_done <= 1'b0;
            end
`else
            tx_data <= head;
`endif
            tx_data_valid <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          if (tx_data_ack) begin
            tx_data_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          tx_data_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
